// File: rtl/audio_fir_decim.sv
// Decimating low-pass FIR for demodulated audio.
// Pops DECIM samples, runs a TAPS-cycle single-multiplier MAC, pushes one output.
module audio_fir_decim #(
  parameter int TAPS  = 32,
  parameter int DECIM = 8,
  parameter int BITS  = 10,
  parameter logic signed [31:0] COEFFS [TAPS] = '{
    -32'sd1, -32'sd1, -32'sd2, -32'sd2,
     32'sd0,  32'sd3,  32'sd8,  32'sd14,
     32'sd21, 32'sd28, 32'sd37, 32'sd45,
     32'sd52, 32'sd58, 32'sd62, 32'sd64,
     32'sd64, 32'sd62, 32'sd58, 32'sd52,
     32'sd45, 32'sd37, 32'sd28, 32'sd21,
     32'sd14, 32'sd8,  32'sd3,  32'sd0,
    -32'sd2, -32'sd2, -32'sd1, -32'sd1
  }
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               input_fifo_empty,
  output logic               input_rd_en,
  input  logic signed [31:0] x_in,
  output logic signed [31:0] y_out,
  output logic               wr_en_out,
  input  logic               out_fifo_full
);

  localparam int JW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [31:0] RND = (32'sd1 <<< BITS) - 32'sd1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    MAC    = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]      cnt;
  logic [JW-1:0]      j;
  logic [JW-1:0]      sidx;
  logic signed [31:0] acc;
  logic signed [31:0] acc_nx;
  logic signed [31:0] prod;
  logic signed [31:0] term;
  logic signed [31:0] s [TAPS];
  logic               last_pop;
  logic               last_tap;

  assign last_pop = input_rd_en && (cnt == CW'(DECIM - 1));
  assign last_tap = (state == MAC) && (j == JW'(TAPS - 1));

  always_comb begin
    state_nx    = state;
    input_rd_en = 1'b0;
    wr_en_out   = 1'b0;
    unique case (state)
      LOAD: begin
        input_rd_en = reset && !input_fifo_empty;
        if (last_pop)
          state_nx = MAC;
      end
      MAC: begin
        if (j == JW'(TAPS - 1))
          state_nx = OUTPUT;
      end
      OUTPUT: begin
        wr_en_out = !out_fifo_full;
        if (!out_fifo_full)
          state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= LOAD;
    else
      state <= state_nx;
  end

  // low 32 bits of the signed product, then round-toward-zero rescale
  assign sidx = JW'(TAPS - 1) - j;

  always_comb begin
    prod = COEFFS[j] * s[sidx];
    if (prod[31])
      term = (prod + RND) >>> BITS;
    else
      term = prod >>> BITS;
    acc_nx = acc + term;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++)
        s[k] <= '0;
    end else if (input_rd_en) begin
      for (int k = 0; k < TAPS - 1; k++)
        s[k] <= s[k+1];
      s[TAPS-1] <= x_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (input_rd_en) begin
      if (last_pop)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j     <= '0;
      acc   <= '0;
      y_out <= '0;
    end else if (last_pop) begin
      j   <= '0;
      acc <= '0;
    end else if (state == MAC) begin
      acc <= acc_nx;
      if (last_tap) begin
        j     <= '0;
        y_out <= acc_nx;
      end else begin
        j <= j + JW'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_fir_decim.sv
// Directed bench for audio_fir_decim: three coefficient sets driven in lockstep
// from one shared input stream, checked against hand-computed outputs.
module tb_audio_fir_decim;

  localparam int TAPS  = 32;
  localparam int DECIM = 8;
  localparam int BITS  = 10;

  localparam logic signed [31:0] C_IMP [TAPS] = '{
    32'sd1,  32'sd2,  32'sd3,  32'sd4,  32'sd5,  32'sd6,  32'sd7,  32'sd8,
    32'sd9,  32'sd10, 32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15, 32'sd16,
    32'sd17, 32'sd18, 32'sd19, 32'sd20, 32'sd21, 32'sd22, 32'sd23, 32'sd24,
    32'sd25, 32'sd26, 32'sd27, 32'sd28, 32'sd29, 32'sd30, 32'sd31, 32'sd32
  };
  localparam logic signed [31:0] C_DC  [TAPS] = '{default: 32'sd32};
  localparam logic signed [31:0] C_RND [TAPS] = '{0: 32'sd1, default: 32'sd0};

  typedef struct {
    bit rst;
    bit starve;
    int x [DECIM];
    int e_imp;
    int e_dc;
    int e_rnd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic empty;
  logic full;
  logic signed [31:0] x_in;
  logic signed [31:0] y_imp, y_dc, y_rnd;
  logic wr_imp, wr_dc, wr_rnd;
  logic rd_imp, rd_dc, rd_rnd;

  int checks = 0;
  int failures = 0;
  vec_t tbl [18];

  always #5 clk = ~clk;

  audio_fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .BITS(BITS), .COEFFS(C_IMP)) u_imp (
    .clk(clk), .reset(reset), .input_fifo_empty(empty), .input_rd_en(rd_imp),
    .x_in(x_in), .y_out(y_imp), .wr_en_out(wr_imp), .out_fifo_full(full)
  );

  audio_fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .BITS(BITS), .COEFFS(C_DC)) u_dc (
    .clk(clk), .reset(reset), .input_fifo_empty(empty), .input_rd_en(rd_dc),
    .x_in(x_in), .y_out(y_dc), .wr_en_out(wr_dc), .out_fifo_full(full)
  );

  audio_fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .BITS(BITS), .COEFFS(C_RND)) u_rnd (
    .clk(clk), .reset(reset), .input_fifo_empty(empty), .input_rd_en(rd_rnd),
    .x_in(x_in), .y_out(y_rnd), .wr_en_out(wr_rnd), .out_fifo_full(full)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit starve, int x0, int xm, int x7,
                              int ei, int ed, int er);
    vec_t v;
    v.rst = rst;
    v.starve = starve;
    v.x[0] = x0;
    for (int k = 1; k < DECIM - 1; k++)
      v.x[k] = xm;
    v.x[DECIM-1] = x7;
    v.e_imp = ei;
    v.e_dc = ed;
    v.e_rnd = er;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    empty = 1'b1;
    full = 1'b0;
    x_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed_group(input int xs [DECIM], input bit starve, output int pops);
    bit popped;
    int guard;
    pops = 0;
    for (int k = 0; k < DECIM; k++) begin
      x_in = xs[k];
      popped = 1'b0;
      guard = 0;
      while (!popped && guard < 100) begin
        empty = starve ? ($urandom_range(0, 1) == 1) : 1'b0;
        #1;
        popped = rd_imp;
        if (popped)
          pops++;
        @(negedge clk);
        guard++;
      end
    end
    empty = 1'b1;
    x_in = '0;
  endtask

  task automatic wait_push(input bit starve, output int lat, output int extra,
                           output bit got);
    lat = 1;
    extra = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      if (starve)
        empty = ($urandom_range(0, 1) == 1);
      #1;
      if (rd_imp)
        extra++;
      if (wr_imp && wr_dc && wr_rnd) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic apply_rows(input int lo, input int hi, input bit keep_first);
    int pops, lat, extra;
    bit got;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].rst && !(keep_first && i == lo))
        do_reset();
      feed_group(tbl[i].x, tbl[i].starve, pops);
      wait_push(tbl[i].starve, lat, extra, got);
      chk($sformatf("row%0d_push", i), got, 1);
      chk($sformatf("row%0d_pops", i), pops + extra, DECIM);
      chk($sformatf("row%0d_latency", i), lat, TAPS + 1);
      chk($sformatf("row%0d_y_imp", i), y_imp, tbl[i].e_imp);
      chk($sformatf("row%0d_y_dc", i), y_dc, tbl[i].e_dc);
      chk($sformatf("row%0d_y_rnd", i), y_rnd, tbl[i].e_rnd);
      empty = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, bad_wr, bad_rd, bad_y, pulses;

    // impulse
    tbl[0]  = mk(1, 0, 1024, 0, 0, 8, 32, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 16, 32, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 24, 32, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32, 32, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    // dc
    tbl[5]  = mk(1, 0, 1024, 1024, 1024, 36, 256, 1);
    tbl[6]  = mk(0, 0, 1024, 1024, 1024, 136, 512, 1);
    tbl[7]  = mk(0, 0, 1024, 1024, 1024, 300, 768, 1);
    tbl[8]  = mk(0, 0, 1024, 1024, 1024, 528, 1024, 1);
    tbl[9]  = mk(0, 0, 1024, 1024, 1024, 528, 1024, 1);
    // rounding toward zero
    tbl[10] = mk(1, 0, 0, 0, -1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, -1025, -1, -32, -1);
    tbl[12] = mk(0, 0, 0, 0, 1025, -8, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, -2048, -10, -64, -2);
    // impulse under input starvation
    tbl[14] = mk(1, 1, 1024, 0, 0, 8, 32, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 16, 32, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 24, 32, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 32, 32, 0);

    reset = 1'b0;
    empty = 1'b0;
    full = 1'b0;
    x_in = 32'sd1024;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_y_imp", y_imp, 0);
    chk("rst_y_dc", y_dc, 0);
    chk("rst_rd", rd_imp, 0);
    chk("rst_wr", wr_imp, 0);

    apply_rows(0, 17, 1'b0);

    // backpressure: hold full for 20 cycles once OUTPUT is reached
    do_reset();
    full = 1'b1;
    feed_group(tbl[0].x, 1'b0, pops);
    repeat (TAPS) @(negedge clk);
    bad_wr = 0;
    bad_rd = 0;
    bad_y = 0;
    for (int c = 0; c < 20; c++) begin
      empty = 1'b0;
      #1;
      if (wr_imp || wr_dc || wr_rnd) bad_wr++;
      if (rd_imp) bad_rd++;
      if (y_imp != 8) bad_y++;
      @(negedge clk);
    end
    chk("bp_wr_low", bad_wr, 0);
    chk("bp_rd_low", bad_rd, 0);
    chk("bp_y_stable", bad_y, 0);
    full = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (wr_imp) pulses++;
      @(negedge clk);
    end
    #1;
    chk("bp_one_push", pulses, 1);
    chk("bp_back_to_load", rd_imp, 1);

    // reset during the MAC of the second output
    do_reset();
    feed_group(tbl[0].x, 1'b0, pops);
    begin
      int lat, extra;
      bit got;
      wait_push(1'b0, lat, extra, got);
      chk("mid_first_y", y_imp, 8);
      @(negedge clk);
    end
    feed_group(tbl[1].x, 1'b0, pops);
    repeat (10) @(negedge clk);
    empty = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_y_imp", y_imp, 0);
    chk("mid_y_dc", y_dc, 0);
    chk("mid_rd", rd_imp, 0);
    chk("mid_wr", wr_imp, 0);
    repeat (2) @(negedge clk);
    empty = 1'b1;
    reset = 1'b1;
    bad_wr = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (wr_imp) bad_wr++;
    end
    chk("mid_no_write", bad_wr, 0);
    apply_rows(0, 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
